// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of the single synchronous memory.
// Port 0 is the CPU bus, port 1 is the loader/DMA engine; bursts are capped only under contention.

module mem_port_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          Clk,
    input  logic          Reset,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          ack0,

    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          ack1,

    output logic [DW-1:0] rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // state | meaning
    // IDLE  | no owner, memory bus parked at zero
    // GNT0  | port 0 (CPU) owns the memory
    // GNT1  | port 1 (loader/DMA) owns the memory
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] burst_cnt;
    logic [3:0] burst_cnt_nxt;
    logic [3:0] burst_inc;
    logic       burst_done;
    logic       last_port;
    logic       last_port_nxt;
    logic       issue0;
    logic       issue1;

    assign issue0 = (state == GNT0) && req0;
    assign issue1 = (state == GNT1) && req1;

    assign gnt0  = (state == GNT0);
    assign gnt1  = (state == GNT1);
    assign rdata = mem_rdata;

    // Saturating count including this cycle's access; the limit matters only under contention.
    assign burst_inc  = (burst_cnt >= BURST_MAX) ? BURST_MAX : burst_cnt + 4'd1;
    assign burst_done = (burst_inc >= BURST_MAX);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
            last_port <= 1'b1;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
            last_port <= last_port_nxt;
            ack0      <= issue0;
            ack1      <= issue1;
        end
    end

    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        last_port_nxt = last_port;

        case (state)
            IDLE: begin
                // On a tie the port that did not own the memory last wins.
                if (req0 && (!req1 || last_port)) begin
                    state_nxt = GNT0;
                end else if (req1) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!req0) begin
                    state_nxt = req1 ? GNT1 : IDLE;
                end else if (req1 && burst_done) begin
                    state_nxt = GNT1;
                end
            end
            GNT1: begin
                if (!req1) begin
                    state_nxt = req0 ? GNT0 : IDLE;
                end else if (req0 && burst_done) begin
                    state_nxt = GNT0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if ((state_nxt != state) && (state_nxt != IDLE)) begin
            burst_cnt_nxt = 4'd0;
            last_port_nxt = (state_nxt == GNT1);
        end else if (issue0 || issue1) begin
            burst_cnt_nxt = burst_inc;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue0) begin
            mem_en    = 1'b1;
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (issue1) begin
            mem_en    = 1'b1;
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked
// against an ownership/tenure model and a shadow copy of memory contents.

module tb_mem_port_arbiter;

    localparam int AW        = 8;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, ack0, gnt1, ack1;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: owner -1 = nobody, tenure access count, last winner, pending ack
    int            m_owner, m_used, m_last, m_ack;
    bit            m_ack_rd;
    logic [DW-1:0] m_ack_dat;
    logic [DW-1:0] shadow [256];

    int hold_left [2];

    always #5 Clk = ~Clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .ack1(ack1),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // write-first synchronous memory with a preload port
    always @(posedge Clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_used   = 0;
        m_last   = 1;
        m_ack    = -1;
        m_ack_rd = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        model_reset();
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the model.
    task automatic cycle();
        bit            rq [2];
        bit            wv [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] wd [2];
        int            o, nxt, used_after;
        bit            iss;
        int            ack_nxt;
        bit            ack_rd_nxt;
        logic [DW-1:0] ack_dat_nxt;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;

        @(negedge Clk);
        rq[0] = req0; rq[1] = req1;
        wv[0] = we0;  wv[1] = we1;
        ad[0] = addr0; ad[1] = addr1;
        wd[0] = wdata0; wd[1] = wdata1;
        o   = m_owner;
        iss = 1'b0;
        exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
        if (o >= 0) begin
            iss = rq[o];
            if (iss) begin
                exp_we    = wv[o];
                exp_addr  = ad[o];
                exp_wdata = wd[o];
            end
        end

        check_val("gnt0", gnt0, o == 0);
        check_val("gnt1", gnt1, o == 1);
        check_val("ack0", ack0, m_ack == 0);
        check_val("ack1", ack1, m_ack == 1);
        if (m_ack_rd) check_val("rdata", rdata, m_ack_dat);
        check_val("mem_en", mem_en, iss);
        check_val("mem_we", mem_we, exp_we);
        check_val("mem_addr", mem_addr, exp_addr);
        check_val("mem_wdata", mem_wdata, exp_wdata);

        ack_nxt     = -1;
        ack_rd_nxt  = 1'b0;
        ack_dat_nxt = '0;
        if (iss) begin
            ack_nxt     = o;
            ack_rd_nxt  = !exp_we;
            ack_dat_nxt = shadow[exp_addr];
            if (exp_we) shadow[exp_addr] = exp_wdata;
        end
        used_after = m_used + (iss ? 1 : 0);

        if (o < 0) begin
            if (rq[0] && rq[1]) nxt = 1 - m_last;
            else if (rq[0])     nxt = 0;
            else if (rq[1])     nxt = 1;
            else                nxt = -1;
        end else if (!rq[o]) begin
            nxt = rq[1-o] ? 1 - o : -1;
        end else if (rq[1-o] && used_after >= MAX_BURST) begin
            nxt = 1 - o;
        end else begin
            nxt = o;
        end

        @(posedge Clk);
        #1;
        if (nxt >= 0 && nxt != o) begin
            m_used = 0;
            m_last = nxt;
        end else begin
            m_used = used_after;
        end
        m_owner   = nxt;
        m_ack     = ack_nxt;
        m_ack_rd  = ack_rd_nxt;
        m_ack_dat = ack_dat_nxt;
    endtask

    task automatic drive_random();
        if (hold_left[0] == 0) begin
            req0 = ~req0;
            hold_left[0] = $urandom_range(8, 1);
        end
        if (hold_left[1] == 0) begin
            req1 = ~req1;
            hold_left[1] = $urandom_range(8, 1);
        end
        hold_left[0]--;
        hold_left[1]--;
        we0    = 1'($urandom_range(1, 0));
        we1    = 1'($urandom_range(1, 0));
        addr0  = 8'($urandom_range(31, 0));
        addr1  = 8'($urandom_range(31, 0));
        wdata0 = 8'($urandom);
        wdata1 = 8'($urandom);
    endtask

    initial begin
        Reset = 1'b0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        pre_we = 1'b1; pre_addr = '0; pre_data = '0;

        for (int i = 0; i < 256; i++) begin
            pre_addr  = 8'(i);
            pre_data  = (i == 8'h10) ? 8'h86 : 8'(i * 7 + 3);
            shadow[i] = pre_data;
            @(posedge Clk);
            #1;
        end
        pre_we = 1'b0;

        // 1: single read of 0x10 right after reset release
        req0 = 1; we0 = 0; addr0 = 8'h10;
        model_reset();
        Reset = 1'b1;
        cycle();
        check_val("t1_gnt0", gnt0, 1);
        check_val("t1_mem_addr", mem_addr, 8'h10);
        cycle();
        check_val("t1_ack0", ack0, 1);
        check_val("t1_rdata", rdata, 8'h86);
        check_val("t1_ack1", ack1, 0);
        req0 = 0;
        cycle();
        cycle();

        // 2: both requesting from reset -> 4/4/4 alternation, no idle gaps
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'h01; addr1 = 8'h02;
        do_reset();
        cycle();
        for (int i = 1; i <= 12; i++) begin
            check_val("t2_gnt0", gnt0, (i <= 4) || (i >= 9));
            check_val("t2_gnt1", gnt1, (i >= 5) && (i <= 8));
            cycle();
        end
        req0 = 0; req1 = 0;
        cycle();
        cycle();

        // 3: port 1 alone writes ten words; no forced release
        req1 = 1; we1 = 1; wdata1 = 8'hA5; addr1 = 8'h20;
        do_reset();
        cycle();
        for (int k = 0; k < 10; k++) begin
            addr1 = 8'(8'h20 + k);
            cycle();
        end
        req1 = 0;
        cycle();
        cycle();
        for (int k = 0; k < 10; k++) check_val("t3_mem", mem[8'h20 + k], 8'hA5);

        // 4 + 6: port 0 writes 0x40, drops req while port 1 waits, port 1 reads it back
        req0 = 1; we0 = 1; addr0 = 8'h40; wdata0 = 8'h3C;
        cycle();
        cycle();
        req0 = 0; req1 = 1; we1 = 0; addr1 = 8'h40;
        cycle();
        check_val("t6_gnt1", gnt1, 1);
        cycle();
        check_val("t4_ack1", ack1, 1);
        check_val("t4_rdata", rdata, 8'h3C);
        req1 = 0;
        cycle();
        cycle();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        cycle();
        check_val("t6_tie_gnt0", gnt0, 1);
        req0 = 0; req1 = 0;
        cycle();
        cycle();

        // 5: reset in the ack cycle of a read kills the ack at once
        req0 = 1; we0 = 0; addr0 = 8'h10;
        do_reset();
        cycle();
        cycle();
        check_val("t5_ack0_pre", ack0, 1);
        #2;
        Reset = 1'b0;
        #1;
        check_val("t5_ack0", ack0, 0);
        check_val("t5_ack1", ack1, 0);
        check_val("t5_gnt0", gnt0, 0);
        check_val("t5_gnt1", gnt1, 0);
        model_reset();
        @(posedge Clk);
        #1;
        req1 = 1; we1 = 0; addr1 = 8'h11;
        Reset = 1'b1;
        cycle();
        cycle();
        check_val("t5_tie_gnt0", gnt0, 1);
        req0 = 0; req1 = 0;
        cycle();
        cycle();

        // random traffic
        hold_left[0] = 0;
        hold_left[1] = 0;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            drive_random();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
